// File: rtl/log_hsaf_pkg.sv
// log_hsaf_pkg: shared types and packed log-word layout for the log-domain
// HSAF datapath.
//   tap_state_e      : tap sequencer FSM states (IDLE, EMIT)
//   LOGW_*           : packed word field positions at the default WIDTH = 16
//   logw_*() helpers : the same positions for any sample width
// Packed log word, MSB first: {valid, sign, log magnitude[WIDTH:0]}.
package log_hsaf_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } tap_state_e;

  localparam int LOGW_WIDTH     = 16;
  localparam int LOGW_VALID_BIT = LOGW_WIDTH + 2;
  localparam int LOGW_SIGN_BIT  = LOGW_WIDTH + 1;
  localparam int LOGW_W         = LOGW_WIDTH + 3;

  function automatic int logw_valid_bit(input int w);
    return w + 2;
  endfunction

  function automatic int logw_sign_bit(input int w);
    return w + 1;
  endfunction

  function automatic int logw_w(input int w);
    return w + 3;
  endfunction

endpackage

// File: rtl/log1_16.sv
// log1_16: Mitchell-style base-2 log of an unsigned magnitude.
//   i_mag [WIDTH-1:0] : unsigned magnitude
//   o_lv              : 1 when i_mag != 0
//   o_lg  [WIDTH:0]   : {leading-one position (IW bits), fraction (FW bits)};
//                       the fraction is the bits below the leading one,
//                       left-aligned and truncated. o_lg = 0 when i_mag == 0.
module log1_16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_mag,
  output logic             o_lv,
  output logic [WIDTH:0]   o_lg
);

  localparam int IW = $clog2(WIDTH) + 1;
  localparam int FW = WIDTH + 1 - IW;

  logic [IW-1:0]    w_pos;
  logic [WIDTH-1:0] w_norm;

  always_comb begin
    w_pos = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i_mag[i]) w_pos = IW'(i);
    end
    // Normalise so the leading one sits at bit WIDTH-1; the fraction is the
    // FW bits directly below it.
    w_norm = i_mag << (IW'(WIDTH - 1) - w_pos);
    o_lv   = |i_mag;
    o_lg   = o_lv ? {w_pos, FW'(w_norm >> (WIDTH - 1 - FW))} : '0;
  end

endmodule

// File: rtl/log_pack.sv
// log_pack: combinational linear-to-log packer (shared with the error path).
//   i_sample [WIDTH-1:0] : signed two's-complement sample
//   o_word   [WIDTH+2:0] : {valid, sign, log1_16(|i_sample|)}
// The most negative input maps to magnitude 2^(WIDTH-1) since the magnitude
// is treated as unsigned.
module log_pack
  import log_hsaf_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_sample,
  output logic [WIDTH+2:0] o_word
);

  logic             w_sign;
  logic [WIDTH-1:0] w_mag;
  logic             w_lv;
  logic [WIDTH:0]   w_lg;

  always_comb begin
    w_sign = i_sample[WIDTH-1];
    w_mag  = w_sign ? -i_sample : i_sample;
  end

  log1_16 #(.WIDTH(WIDTH)) u_log1_16 (
    .i_mag (w_mag),
    .o_lv  (w_lv),
    .o_lg  (w_lg)
  );

  always_comb begin
    o_word                        = '0;
    o_word[logw_valid_bit(WIDTH)] = w_lv;
    o_word[logw_sign_bit(WIDTH)]  = w_sign;
    o_word[WIDTH:0]               = w_lg;
  end

endmodule

// File: rtl/log_tap_seq.sv
// log_tap_seq: input-side tap sequencer for the log-domain HSAF datapath.
// Accepts one linear sample per handshake, packs it to a log word, pushes it
// into a TAPS-deep delay line and streams the TAPS tap words, newest first.
//   clk, reset            : clock, synchronous active-high reset
//   in_sample/in_valid/in_ready : sample input handshake
//   log_x_n/tap_idx/out_valid/out_ready/out_last : tap word stream
//   flush                 : clears the delay line (only with LOG_TAP_FLUSH_EN)
// Build option: define LOG_TAP_FLUSH_EN to add the flush input.
module log_tap_seq
  import log_hsaf_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int TAPS  = 4,
  localparam int TW    = $clog2(TAPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_sample,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH+2:0] log_x_n,
  output logic [TW-1:0]    tap_idx,
  output logic             out_valid,
`ifdef LOG_TAP_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             out_ready,
  output logic             out_last
);

  localparam int LW = logw_w(WIDTH);

  tap_state_e      r_state;
  tap_state_e      w_state_nx;
  logic [TW-1:0]   r_cnt;
  logic [TW-1:0]   w_cnt_nx;
  logic [LW-1:0]   r_tap [TAPS];
  logic            r_flush_pend;
  logic            w_flush_pend_nx;
  logic [LW-1:0]   w_word;
  logic            w_flush;
  logic            w_clear;
  logic            w_last;
  logic            w_accept;

`ifdef LOG_TAP_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  log_pack #(.WIDTH(WIDTH)) u_log_pack (
    .i_sample (in_sample),
    .o_word   (w_word)
  );

  // State register, beat counter and delay line.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      for (int unsigned k = 0; k < TAPS; k++) r_tap[k] <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_flush_pend <= w_flush_pend_nx;
      if (w_clear) begin
        for (int unsigned k = 0; k < TAPS; k++) r_tap[k] <= '0;
      end else if (w_accept) begin
        r_tap[0] <= w_word;
        for (int unsigned k = 1; k < TAPS; k++) r_tap[k] <= r_tap[k-1];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt;
    w_flush_pend_nx = r_flush_pend;
    case (r_state)
      IDLE: begin
        if (w_clear) w_flush_pend_nx = 1'b0;
        if (w_accept) begin
          w_state_nx = EMIT;
          w_cnt_nx   = '0;
        end
      end
      EMIT: begin
        // A flush mid-stream is deferred so the current stream is unchanged.
        if (w_flush) w_flush_pend_nx = 1'b1;
        if (out_ready) begin
          if (w_last) begin
            w_cnt_nx   = '0;
            w_state_nx = w_accept ? EMIT : IDLE;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Outputs and handshake.
  always_comb begin
    w_last    = (r_state == EMIT) && (r_cnt == TW'(TAPS - 1));
    w_clear   = (r_state == IDLE) && (w_flush || r_flush_pend);
    in_ready  = 1'b0;
    if (!reset) begin
      if (r_state == IDLE) in_ready = !(w_flush || r_flush_pend);
      else                 in_ready = w_last && out_ready && !w_flush && !r_flush_pend;
    end
    w_accept  = in_valid && in_ready;
    out_valid = (r_state == EMIT);
    out_last  = w_last;
    log_x_n   = (r_state == EMIT) ? r_tap[r_cnt] : '0;
    tap_idx   = (r_state == EMIT) ? r_cnt : '0;
  end

endmodule

// File: tb/tb_log_tap_seq.sv
module tb_log_tap_seq;

  localparam int WIDTH = 16;
  localparam int TAPS  = 4;
  localparam int LW    = WIDTH + 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_sample;
  logic             in_valid;
  logic             in_ready;
  logic [LW-1:0]    log_x_n;
  logic [1:0]       tap_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
`ifdef LOG_TAP_FLUSH_EN
  logic             flush = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [LW-1:0] m_tap [TAPS];

  typedef struct {
    logic [WIDTH-1:0] x;
    logic [LW-1:0]    w;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  log_tap_seq #(.WIDTH(WIDTH), .TAPS(TAPS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_sample (in_sample),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .log_x_n   (log_x_n),
    .tap_idx   (tap_idx),
    .out_valid (out_valid),
`ifdef LOG_TAP_FLUSH_EN
    .flush     (flush),
`endif
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model(input logic [LW-1:0] w);
    for (int k = TAPS - 1; k > 0; k--) m_tap[k] = m_tap[k-1];
    m_tap[0] = w;
  endtask

  task automatic clear_model();
    for (int k = 0; k < TAPS; k++) m_tap[k] = '0;
  endtask

  task automatic chk_beat(input int b, input logic exp_rdy);
    chk($sformatf("beat%0d_valid", b), 32'(out_valid), 32'd1);
    chk($sformatf("beat%0d_idx", b),   32'(tap_idx),   32'(b));
    chk($sformatf("beat%0d_data", b),  32'(log_x_n),   32'(m_tap[b]));
    chk($sformatf("beat%0d_last", b),  32'(out_last),  32'(b == TAPS - 1));
    chk($sformatf("beat%0d_rdy", b),   32'(in_ready),  32'(exp_rdy));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_last"},  32'(out_last),  32'd0);
    chk({tag, "_data"},  32'(log_x_n),   32'd0);
  endtask

  task automatic run_single(input vec_t v);
    in_sample = v.x;
    in_valid  = 1'b1;
    #1;
    chk("single_acc_rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    push_model(v.w);
    for (int b = 0; b < TAPS; b++) begin
      #1;
      chk_beat(b, b == TAPS - 1);
      step();
    end
    #1;
    chk_idle("single_end");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'h0003, 19'h41800};
    tbl[1] = '{16'hFFFF, 19'h60000};
    tbl[2] = '{16'h0000, 19'h00000};
    tbl[3] = '{16'h8000, 19'h6F000};
    tbl[4] = '{16'h0064, 19'h46900};
    tbl[5] = '{16'hFF9C, 19'h66900};
    tbl[6] = '{16'h7FFF, 19'h4EFFF};
    tbl[7] = '{16'h0005, 19'h42400};
    clear_model();

    reset     = 1'b1;
    in_sample = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    #1;
    chk_idle("post_rst");
    chk("post_rst_idx", 32'(tap_idx), 32'd0);
    chk("post_rst_rdy", 32'(in_ready), 32'd1);

    // Reset then one sample, then sign and edge values.
    for (int i = 0; i < 4; i++) run_single(tbl[i]);

    // Back-to-back overlap with in_valid held high.
    in_sample = tbl[4].x;
    in_valid  = 1'b1;
    #1;
    chk("ovl_acc_rdy", 32'(in_ready), 32'd1);
    step();
    push_model(tbl[4].w);
    for (int s = 4; s < 8; s++) begin
      if (s < 7) in_sample = tbl[s+1].x;
      else       in_valid  = 1'b0;
      for (int b = 0; b < TAPS; b++) begin
        #1;
        chk_beat(b, b == TAPS - 1);
        step();
        if (b == TAPS - 1 && s < 7) push_model(tbl[s+1].w);
      end
    end
    #1;
    chk_idle("ovl_end");

    // Backpressure at cnt = 2 with a pending sample held at the input.
    in_sample = tbl[7].x;
    in_valid  = 1'b1;
    step();
    push_model(tbl[7].w);
    in_sample = tbl[6].x;
    for (int b = 0; b < 2; b++) begin
      #1;
      chk_beat(b, 1'b0);
      step();
    end
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk_beat(2, 1'b0);
      step();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int b = 2; b < TAPS; b++) begin
      #1;
      chk_beat(b, b == TAPS - 1);
      step();
    end
    #1;
    chk_idle("bp_end");

    // Reset mid-stream at cnt = 1.
    in_sample = tbl[4].x;
    in_valid  = 1'b1;
    step();
    push_model(tbl[4].w);
    in_valid = 1'b0;
    #1;
    chk_beat(0, 1'b0);
    step();
    #1;
    chk_beat(1, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_rdy", 32'(in_ready), 32'd0);
    step();
    reset = 1'b0;
    clear_model();
    #1;
    chk_idle("midrst");
    chk("midrst_idle_rdy", 32'(in_ready), 32'd1);
    run_single(tbl[5]);

`ifdef LOG_TAP_FLUSH_EN
    // Flush pulse at cnt = 1 with a sample waiting: stream completes, overlap
    // is cancelled, the next IDLE cycle blocks accept and clears the taps.
    in_sample = tbl[6].x;
    in_valid  = 1'b1;
    step();
    push_model(tbl[6].w);
    in_sample = tbl[7].x;
    #1;
    chk_beat(0, 1'b0);
    step();
    #1;
    chk_beat(1, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int b = 2; b < TAPS; b++) begin
      #1;
      chk_beat(b, 1'b0);
      step();
    end
    #1;
    chk_idle("flush_idle");
    chk("flush_blk_rdy", 32'(in_ready), 32'd0);
    step();
    clear_model();
    #1;
    chk("flush_acc_rdy", 32'(in_ready), 32'd1);
    step();
    push_model(tbl[7].w);
    in_valid = 1'b0;
    for (int b = 0; b < TAPS; b++) begin
      #1;
      chk_beat(b, b == TAPS - 1);
      step();
    end
    #1;
    chk_idle("flush_end");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
